// File: rtl/dfr_pkg.sv
// Shared types and helpers for the DFR readout layer.
// Holds the readout FSM state encoding, the accumulator width function and the
// saturation helpers used when DFR_READOUT_SATURATE_EN is defined.
package dfr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } readout_state_t;

  // Working width of the saturation helpers; the shifted accumulator must fit.
  localparam int SAT_W = 160;

  // Full-precision accumulator: DW x DW product plus headroom for VN additions.
  function automatic int ACC_WIDTH(input int dw, input int vn);
    return 2 * dw + $clog2(vn);
  endfunction

  // Largest positive value representable in dw signed bits.
  function automatic logic signed [SAT_W-1:0] sat_max(input int dw);
    logic signed [SAT_W-1:0] one;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    return (one <<< (dw - 1)) - one;
  endfunction

  // True when v does not fit in dw signed bits.
  function automatic logic sat_hit(input logic signed [SAT_W-1:0] v, input int dw);
    return (v > sat_max(dw)) || (v < ~sat_max(dw));
  endfunction

  // Clamp v to the signed range of dw bits.
  function automatic logic signed [SAT_W-1:0] sat_clamp(input logic signed [SAT_W-1:0] v,
                                                        input int dw);
    logic signed [SAT_W-1:0] res;
    if (v > sat_max(dw)) begin
      res = sat_max(dw);
    end else if (v < ~sat_max(dw)) begin
      res = ~sat_max(dw);
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/dfr_mac_unit.sv
// Registered signed multiply-accumulate with clear and enable.
// With clr_i and en_i together the accumulator restarts from the current product.
// acc_next_o exposes the value the accumulator takes at the next edge so a
// consumer can register a result in the same cycle the last product lands.
module dfr_mac_unit #(
  parameter int DW    = 32,
  parameter int ACC_W = 68
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [DW-1:0]    a_i,
  input  logic signed [DW-1:0]    b_i,
  output logic signed [ACC_W-1:0] acc_next_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod     = a_i * b_i;
  assign prod_ext = ACC_W'(prod);

  // Next accumulator value: load, accumulate, clear or hold.
  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      if (clr_i) begin
        acc_d = prod_ext;
      end else begin
        acc_d = acc_q + prod_ext;
      end
    end else if (clr_i) begin
      acc_d = '0;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/dfr_readout_mac.sv
// DFR readout layer: per sample, dot product of VIRTUAL_NODES reservoir states
// with the trained weights, scaled back to the Q format and written out.
// Optional build macro: DFR_READOUT_SATURATE_EN (clamp instead of wrap, adds sat_flag).
// One sample takes VIRTUAL_NODES+2 cycles: VN read cycles, one drain, one write.
module dfr_readout_mac
  import dfr_pkg::*;
#(
  parameter int VIRTUAL_NODES                = 10,
  parameter int RESERVOIR_DATA_WIDTH         = 32,
  parameter int RESERVOIR_HISTORY_ADDR_WIDTH = 20,
  parameter int OUTPUT_ADDR_WIDTH            = 16,
  parameter int FRAC_BITS                    = 16,
  localparam int DW    = RESERVOIR_DATA_WIDTH,
  localparam int RHAW  = RESERVOIR_HISTORY_ADDR_WIDTH,
  localparam int OAW   = OUTPUT_ADDR_WIDTH,
  localparam int VN_AW = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1
) (
  input  logic             S_AXI_ACLK,
  input  logic             S_AXI_ARESETN,
  input  logic             start,
  input  logic [OAW-1:0]   num_samples,
  output logic             busy,
  output logic             done,
  output logic             res_rd_en,
  output logic [RHAW-1:0]  res_rd_addr,
  input  logic [DW-1:0]    res_rd_data,
  output logic             w_rd_en,
  output logic [VN_AW-1:0] w_rd_addr,
  input  logic [DW-1:0]    w_rd_data,
  output logic             out_wr_en,
  output logic [OAW-1:0]   out_wr_addr,
`ifdef DFR_READOUT_SATURATE_EN
  output logic [DW-1:0]    out_wr_data,
  output logic             sat_flag
`else
  output logic [DW-1:0]    out_wr_data
`endif
);

  localparam int ACC_W = ACC_WIDTH(DW, VIRTUAL_NODES);

  readout_state_t   state_q, state_d;
  logic [VN_AW-1:0] node_q, node_d;
  logic [OAW-1:0]   sample_q, sample_d;
  logic [OAW-1:0]   nsamp_q, nsamp_d;
  logic [RHAW-1:0]  base_q, base_d;
  logic             vld_q, first_q;

  logic             busy_q, done_q, rd_en_q, wr_en_q;
  logic [RHAW-1:0]  res_rd_addr_q;
  logic [VN_AW-1:0] w_rd_addr_q;
  logic [OAW-1:0]   wr_addr_q;
  logic [DW-1:0]    wr_data_q;

  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] acc_shift;
  logic [DW-1:0]           result;
  logic                    start_ok;

  // Operands arrive one cycle after the read; the first node of a sample restarts the sum.
  dfr_mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i      (S_AXI_ACLK),
    .rst_ni     (S_AXI_ARESETN),
    .clr_i      (first_q),
    .en_i       (vld_q),
    .a_i        (res_rd_data),
    .b_i        (w_rd_data),
    .acc_next_o (acc_next)
  );

  assign acc_shift = acc_next >>> FRAC_BITS;
  assign start_ok  = (state_q == IDLE) && start;

`ifdef DFR_READOUT_SATURATE_EN
  logic signed [SAT_W-1:0] acc_wide;
  logic                    sat_q;
  assign acc_wide = SAT_W'(acc_shift);
  assign result   = DW'(sat_clamp(acc_wide, DW));
  assign sat_flag = sat_q;

  // Sticky saturation flag, cleared by an accepted start.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sat_q <= 1'b0;
    end else if (start_ok) begin
      sat_q <= 1'b0;
    end else if ((state_q == DRAIN) && sat_hit(acc_wide, DW)) begin
      sat_q <= 1'b1;
    end else begin
      sat_q <= sat_q;
    end
  end
`else
  assign result = DW'(acc_shift);
`endif

  // Readout sequencing: next state and counters.
  always_comb begin
    state_d  = state_q;
    node_d   = node_q;
    sample_d = sample_q;
    nsamp_d  = nsamp_q;
    base_d   = base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nsamp_d  = num_samples;
          sample_d = '0;
          base_d   = '0;
          node_d   = '0;
          state_d  = (num_samples == '0) ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (node_q == VN_AW'(VIRTUAL_NODES - 1)) begin
          state_d = DRAIN;
        end else begin
          node_d = node_q + VN_AW'(1);
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        if (sample_q == nsamp_q - OAW'(1)) begin
          state_d = DONE;
        end else begin
          sample_d = sample_q + OAW'(1);
          base_d   = base_q + RHAW'(VIRTUAL_NODES);
          node_d   = '0;
          state_d  = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q       <= IDLE;
      node_q        <= '0;
      sample_q      <= '0;
      nsamp_q       <= '0;
      base_q        <= '0;
      vld_q         <= 1'b0;
      first_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      res_rd_addr_q <= '0;
      w_rd_addr_q   <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      node_q        <= node_d;
      sample_q      <= sample_d;
      nsamp_q       <= nsamp_d;
      base_q        <= base_d;
      vld_q         <= rd_en_q;
      first_q       <= rd_en_q && (w_rd_addr_q == '0);
      busy_q        <= (state_d == RUN) || (state_d == DRAIN) || (state_d == WRITE);
      done_q        <= (state_d == DONE);
      rd_en_q       <= (state_d == RUN);
      res_rd_addr_q <= (state_d == RUN) ? (base_d + RHAW'(node_d)) : '0;
      w_rd_addr_q   <= (state_d == RUN) ? node_d : '0;
      wr_en_q       <= (state_d == WRITE);
      wr_addr_q     <= (state_d == WRITE) ? sample_d : '0;
      wr_data_q     <= (state_d == WRITE) ? result : '0;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign res_rd_en   = rd_en_q;
  assign res_rd_addr = res_rd_addr_q;
  assign w_rd_en     = rd_en_q;
  assign w_rd_addr   = w_rd_addr_q;
  assign out_wr_en   = wr_en_q;
  assign out_wr_addr = wr_addr_q;
  assign out_wr_data = wr_data_q;

endmodule
